// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the system-ID check sequencer.
// State encoding, slave address values and the counter width.
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    SETTLE = 3'd0,
    RD_ID  = 3'd1,
    RD_TS  = 3'd2,
    CMP    = 3'd3,
    IDLE   = 3'd4
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int   CNT_W         = 16;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sysid_ctrl_timer.sv
// Loadable down-counter with zero flag.
// Load wins over enable; the count parks at zero.
module sysid_ctrl_timer
  import sysid_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads ID and timestamp from the system-ID slave and checks them.
// Runs once after reset, then on start or periodic timer expiry.
module sysid_check_ctrl
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXP_ID     = 32'd0,
  parameter logic [31:0] EXP_TS     = 32'd1537779467,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned PERIOD     = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_err,
  output logic        ts_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  check_count
);

  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYC - 1);

  state_e      r_state;
  logic        r_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_id_err;
  logic        r_ts_err;
  logic [31:0] r_id;
  logic [31:0] r_ts;
  logic [7:0]  r_cnt;

  logic w_tmr_load;
  logic w_tmr_en;
  logic w_tmr_zero;
  logic w_expire;
  logic w_launch;

  assign w_launch = (r_state == IDLE) && (start || w_expire);

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    unique case (r_state)
      SETTLE, RD_ID, RD_TS: begin
        w_tmr_load = w_tmr_zero;
        w_tmr_en   = !w_tmr_zero;
      end
      IDLE:    w_tmr_load = w_launch;
      default: ;
    endcase
  end

  // One counter serves the settle wait and both read-latency waits
  sysid_ctrl_timer #(
    .RST_VAL(SET_LD)
  ) u_tmr (
    .clk       (clock),
    .rst_n     (reset_n),
    .i_load    (w_tmr_load),
    .i_load_val(LAT_LD),
    .i_en      (w_tmr_en),
    .o_zero    (w_tmr_zero)
  );

  if (PERIOD > 0) begin : g_period
    localparam logic [CNT_W-1:0] PER_LD = CNT_W'(PERIOD - 1);
    logic w_per_zero;
    sysid_ctrl_timer #(
      .RST_VAL(PER_LD)
    ) u_per (
      .clk       (clock),
      .rst_n     (reset_n),
      .i_load    (r_state != IDLE),
      .i_load_val(PER_LD),
      .i_en      (1'b1),
      .o_zero    (w_per_zero)
    );
    assign w_expire = w_per_zero;
  end else begin : g_noper
    assign w_expire = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= SETTLE;
      r_addr   <= SYSID_ADDR_ID;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_id_err <= 1'b0;
      r_ts_err <= 1'b0;
      r_id     <= '0;
      r_ts     <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SETTLE: begin
          r_busy <= 1'b1;
          if (w_tmr_zero) r_state <= RD_ID;
        end
        RD_ID: begin
          if (w_tmr_zero) begin
            r_id    <= sysid_readdata;
            r_addr  <= SYSID_ADDR_TS;
            r_state <= RD_TS;
          end
        end
        RD_TS: begin
          if (w_tmr_zero) begin
            r_ts    <= sysid_readdata;
            r_addr  <= SYSID_ADDR_ID;
            r_state <= CMP;
          end
        end
        CMP: begin
          r_id_err <= (r_id != EXP_ID);
          r_ts_err <= (r_ts != EXP_TS);
          r_pass   <= (r_id == EXP_ID) && (r_ts == EXP_TS);
          r_done   <= 1'b1;
          r_cnt    <= sat_inc(r_cnt);
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        IDLE: begin
          if (w_launch) begin
            r_busy  <= 1'b1;
            r_state <= RD_ID;
          end
        end
        default: begin
          r_addr  <= SYSID_ADDR_ID;
          r_state <= SETTLE;
        end
      endcase
    end
  end

  assign sysid_address = r_addr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign id_err        = r_id_err;
  assign ts_err        = r_ts_err;
  assign id_value      = r_id;
  assign ts_value      = r_ts;
  assign check_count   = r_cnt;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl: three instances cover
// READ_LAT=1, READ_LAT=3 and PERIOD=100 configurations.
module tb_sysid_check_ctrl;

  localparam logic [31:0] TS = 32'd1537779467;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_bc;
  logic start_a, start_b, start_c;
  logic [31:0] id_a, ts_a;

  logic addr_a, busy_a, done_a, pass_a, ide_a, tse_a;
  logic addr_b, busy_b, done_b, pass_b, ide_b, tse_b;
  logic addr_c, busy_c, done_c, pass_c, ide_c, tse_c;
  logic [31:0] idv_a, tsv_a, idv_b, tsv_b, idv_c, tsv_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic [7:0]  cnt_a, cnt_b, cnt_c;

  assign rd_a = addr_a ? ts_a : id_a;
  assign rd_b = addr_b ? TS : 32'd0;
  assign rd_c = addr_c ? TS : 32'd0;

  sysid_check_ctrl #(.READ_LAT(1), .SETTLE_CYC(16), .PERIOD(0)) u_a (
    .clock(clk), .reset_n(rst_a), .start(start_a),
    .sysid_address(addr_a), .sysid_readdata(rd_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .id_err(ide_a), .ts_err(tse_a),
    .id_value(idv_a), .ts_value(tsv_a), .check_count(cnt_a));

  sysid_check_ctrl #(.READ_LAT(3), .SETTLE_CYC(4), .PERIOD(0)) u_b (
    .clock(clk), .reset_n(rst_bc), .start(start_b),
    .sysid_address(addr_b), .sysid_readdata(rd_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .id_err(ide_b), .ts_err(tse_b),
    .id_value(idv_b), .ts_value(tsv_b), .check_count(cnt_b));

  sysid_check_ctrl #(.READ_LAT(1), .SETTLE_CYC(4), .PERIOD(100)) u_c (
    .clock(clk), .reset_n(rst_bc), .start(start_c),
    .sysid_address(addr_c), .sysid_readdata(rd_c),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .id_err(ide_c), .ts_err(tse_c),
    .id_value(idv_c), .ts_value(tsv_c), .check_count(cnt_c));

  int checks = 0;
  int errors = 0;
  int ndone_b = 0;

  always @(negedge clk) if (done_b) ndone_b <= ndone_b + 1;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        pass;
    logic        ide;
    logic        tse;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic pulse(input int sel);
    case (sel)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int lim, output int cyc);
    cyc = 0;
    while (!done_of(sel) && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(done_of(sel)), 32'd1);
  endtask

  task automatic idle_run(output int n);
    n = 0;
    while (!busy_c && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at the negedge where reset_n of instance a is released
  task automatic boot_mon(input string tag);
    logic [31:0] va, vd, vb;
    va = '0;
    vd = '0;
    vb = '0;
    for (int i = 0; i < 25; i++) begin
      #1;
      va[i] = addr_a;
      vd[i] = done_a;
      vb[i] = busy_a;
      if (i == 0) begin
        chk({tag, "_rst_pass"}, 32'(pass_a), 32'd0);
        chk({tag, "_rst_cnt"}, 32'(cnt_a), 32'd0);
        chk({tag, "_rst_tsv"}, tsv_a, 32'd0);
      end
      @(negedge clk);
    end
    chk({tag, "_addr_seq"}, va, 32'h0002_0000);
    chk({tag, "_done_seq"}, vd, 32'h0008_0000);
    chk({tag, "_busy_seq"}, vb, 32'h0007_fffe);
    chk({tag, "_pass"}, 32'(pass_a), 32'd1);
    chk({tag, "_cnt"}, 32'(cnt_a), 32'd1);
    chk({tag, "_idv"}, idv_a, 32'd0);
    chk({tag, "_tsv"}, tsv_a, TS);
  endtask

  initial begin
    int cyc, n, c0, nd0;
    vt[0] = '{32'd0,         TS,           1'b1, 1'b0, 1'b0};
    vt[1] = '{32'h0000_0005, TS,           1'b0, 1'b1, 1'b0};
    vt[2] = '{32'd0,         TS + 32'd1,   1'b0, 1'b0, 1'b1};
    vt[3] = '{32'hffff_ffff, 32'd0,        1'b0, 1'b1, 1'b1};
    vt[4] = '{32'h8000_0000, TS,           1'b0, 1'b1, 1'b0};
    vt[5] = '{32'd0,         TS ^ 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vt[6] = '{32'd0,         TS,           1'b1, 1'b0, 1'b0};

    rst_a = 1'b0;
    rst_bc = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    id_a = 32'd0;
    ts_a = TS;

    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    rst_bc = 1'b1;
    boot_mon("t1");

    for (int i = 0; i < 7; i++) begin
      id_a = vt[i].id;
      ts_a = vt[i].ts;
      pulse(0);
      wait_done(0, 20, cyc);
      chk($sformatf("v%0d_lat", i), 32'(cyc), 32'd3);
      chk($sformatf("v%0d_pass", i), 32'(pass_a), 32'(vt[i].pass));
      chk($sformatf("v%0d_ide", i), 32'(ide_a), 32'(vt[i].ide));
      chk($sformatf("v%0d_tse", i), 32'(tse_a), 32'(vt[i].tse));
      chk($sformatf("v%0d_idv", i), idv_a, vt[i].id);
      chk($sformatf("v%0d_tsv", i), tsv_a, vt[i].ts);
      chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(i + 2));
    end

    c0 = int'(cnt_b);
    nd0 = ndone_b;
    chk("t3_idle", 32'(busy_b), 32'd0);
    pulse(1);
    wait_done(1, 30, cyc);
    chk("t3_lat", 32'(cyc), 32'd7);
    chk("t3_cnt1", 32'(cnt_b), 32'(c0 + 1));
    @(negedge clk);
    pulse(1);
    repeat (2) @(negedge clk);
    pulse(1);
    wait_done(1, 30, cyc);
    chk("t3_lat2", 32'(cyc), 32'd4);
    repeat (20) @(negedge clk);
    chk("t3_ndone", 32'(ndone_b - nd0), 32'd2);
    chk("t3_cnt2", 32'(cnt_b), 32'(c0 + 2));
    chk("t3_pass", 32'(pass_b), 32'd1);

    wait_done(2, 300, cyc);
    c0 = int'(cnt_c);
    idle_run(n);
    chk("t4_idle1", 32'(n), 32'd100);
    wait_done(2, 10, cyc);
    chk("t4_rd_lat", 32'(cyc), 32'd3);
    chk("t4_cnt1", 32'(cnt_c), 32'(c0 + 1));
    repeat (99) @(negedge clk);
    chk("t4_pre_exp", 32'(busy_c), 32'd0);
    pulse(2);
    chk("t4_launch", 32'(busy_c), 32'd1);
    wait_done(2, 10, cyc);
    chk("t4_lat", 32'(cyc), 32'd3);
    chk("t4_cnt2", 32'(cnt_c), 32'(c0 + 2));
    idle_run(n);
    chk("t4_idle2", 32'(n), 32'd100);
    wait_done(2, 10, cyc);
    chk("t4_cnt3", 32'(cnt_c), 32'(c0 + 3));
    chk("t4_pass", 32'(pass_c), 32'd1);

    pulse(0);
    @(negedge clk);
    #1;
    chk("t5_pre_addr", 32'(addr_a), 32'd1);
    chk("t5_pre_pass", 32'(pass_a), 32'd1);
    rst_a = 1'b0;
    #1;
    chk("t5_addr", 32'(addr_a), 32'd0);
    chk("t5_busy", 32'(busy_a), 32'd0);
    chk("t5_pass", 32'(pass_a), 32'd0);
    chk("t5_cnt", 32'(cnt_a), 32'd0);
    chk("t5_tsv", tsv_a, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    boot_mon("t5");

    for (int i = 0; i < 300; i++) begin
      pulse(0);
      wait_done(0, 10, cyc);
      if (i == 252) chk("t6_254", 32'(cnt_a), 32'd254);
      if (i == 253) chk("t6_255", 32'(cnt_a), 32'd255);
    end
    chk("t6_sat", 32'(cnt_a), 32'd255);
    chk("t6_pass", 32'(pass_a), 32'd1);
    id_a = 32'h0000_0005;
    pulse(0);
    wait_done(0, 10, cyc);
    chk("t6_bad_pass", 32'(pass_a), 32'd0);
    chk("t6_bad_ide", 32'(ide_a), 32'd1);
    chk("t6_bad_cnt", 32'(cnt_a), 32'd255);
    id_a = 32'd0;
    pulse(0);
    wait_done(0, 10, cyc);
    chk("t6_ok_pass", 32'(pass_a), 32'd1);
    chk("t6_ok_ide", 32'(ide_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
